// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the GRF write port, with a newest-first bypass lookup for pending writes.
// Latency: a push is presented at the GRF port no earlier than the next cycle; bypass lookup is combinational.
// Backpressure: in_ready drops only when full and not draining; wb_stall holds the head. Optional WB_TRACE_EN prints each GRF write.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [4:0]    in_addr,
    input  logic [31:0]   in_data,
    input  logic          wb_stall,
    output logic          grf_we,
    output logic [4:0]    grf_addr,
    output logic [31:0]   grf_data,
    output logic [31:0]   grf_pc,
    input  logic [4:0]    rd_addr_a,
    input  logic [4:0]    rd_addr_b,
    output logic          hit_a,
    output logic          hit_b,
    output logic [31:0]   byp_data_a,
    output logic [31:0]   byp_data_b,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q, count_d;
    logic          drain, push;

    assign drain    = (count_q != '0) && !wb_stall && !reset;
    assign in_ready = (count_q < FULL) || drain;
    assign push     = in_valid && in_ready && (in_addr != 5'd0);
    assign grf_we   = drain;
    assign count    = count_q;

    always_comb begin
        grf_addr = 5'd0;
        grf_data = 32'd0;
        grf_pc   = 32'd0;
        if (count_q != '0) begin
            grf_addr = mem_q[head_q].addr;
            grf_data = mem_q[head_q].data;
            grf_pc   = mem_q[head_q].pc;
        end
    end

    always_comb begin
        case ({push, drain})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to newest so a later match overwrites an earlier one.
    always_comb begin
        logic [AW-1:0] idx;
        hit_a      = 1'b0;
        hit_b      = 1'b0;
        byp_data_a = 32'd0;
        byp_data_b = 32'd0;
        idx        = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + i[AW-1:0];
            if ((AW+1)'(i) < count_q) begin
                if (rd_addr_a != 5'd0 && mem_q[idx].addr == rd_addr_a) begin
                    hit_a      = 1'b1;
                    byp_data_a = mem_q[idx].data;
                end
                if (rd_addr_b != 5'd0 && mem_q[idx].addr == rd_addr_b) begin
                    hit_b      = 1'b1;
                    byp_data_b = mem_q[idx].data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[tail_q] <= '{pc: in_pc, addr: in_addr, data: in_data};
                tail_q        <= tail_q + AW'(1);
            end
            if (drain) begin
                head_q <= head_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && grf_we) begin
            $display("@%h: $%d <= %h", grf_pc, grf_addr, grf_data);
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: a queue-based reference model predicts GRF writes, count, ready and bypass results.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic        wb_stall = 1'b0;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_data, grf_pc;
    logic [4:0]  rd_addr_a = '0, rd_addr_b = '0;
    logic        hit_a, hit_b;
    logic [31:0] byp_data_a, byp_data_b;
    logic [AW:0] count;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;
    int writes_seen = 0;

    req_t sb[$];

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_addr(in_addr), .in_data(in_data),
        .wb_stall(wb_stall),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data), .grf_pc(grf_pc),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .hit_a(hit_a), .hit_b(hit_b),
        .byp_data_a(byp_data_a), .byp_data_b(byp_data_b),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [4:0] a, output bit h, output logic [31:0] d);
        h = 0;
        d = '0;
        if (a != 5'd0) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].addr == a) begin
                    h = 1;
                    d = sb[i].data;
                    break;
                end
            end
        end
    endfunction

    // Predictor: applies the queue rules at each edge to the reference queue.
    always @(posedge clk) begin
        int  n;
        bit  drn, rdy;
        n = sb.size();
        if (reset) begin
            sb.delete();
            started <= 1;
        end else begin
            drn = (n != 0) && !wb_stall;
            rdy = (n < DEPTH) || drn;
            if (drn) void'(sb.pop_front());
            if (in_valid && rdy && in_addr != 5'd0)
                sb.push_back('{pc: in_pc, addr: in_addr, data: in_data});
        end
    end

    // Monitor: compares DUT outputs against the reference queue away from the active edge.
    always @(negedge clk) begin
        int          n;
        bit          drn, rdy, ha, hb;
        logic [31:0] da, db;
        if (started) begin
            n   = sb.size();
            drn = (n != 0) && !wb_stall && !reset;
            rdy = (n < DEPTH) || drn;
            chk("count", 32'(count), 32'(n));
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("grf_we", 32'(grf_we), 32'(drn));
            if (n != 0) begin
                chk("grf_addr", 32'(grf_addr), 32'(sb[0].addr));
                chk("grf_data", grf_data, sb[0].data);
                chk("grf_pc", grf_pc, sb[0].pc);
            end else begin
                chk("grf_addr_empty", 32'(grf_addr), 32'd0);
                chk("grf_data_empty", grf_data, 32'd0);
                chk("grf_pc_empty", grf_pc, 32'd0);
            end
            if (grf_we) writes_seen++;
            lookup(rd_addr_a, ha, da);
            lookup(rd_addr_b, hb, db);
            chk("hit_a", 32'(hit_a), 32'(ha));
            chk("byp_data_a", byp_data_a, da);
            chk("hit_b", 32'(hit_b), 32'(hb));
            chk("byp_data_b", byp_data_b, db);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_pc    = p;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL send_timeout addr=%0d not accepted within 64 cycles, required acceptance", a);
        in_valid = 1'b0;
    endtask

    initial begin
        int  ws;
        bit  acc;

        // Reset held two cycles with a request presented.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_addr  = 5'd3;
        in_data  = 32'h55;
        rd_addr_a = 5'd3;
        idle(2);
        in_valid = 1'b0;
        reset    = 1'b0;

        // Single write.
        send(5'd5, 32'h1234, 32'h3000);
        idle(3);

        // Fill while stalled, fifth request held until the stall releases.
        wb_stall = 1'b1;
        for (int i = 1; i <= 4; i++) send(5'(i), 32'h100 + 32'(i), 32'h4000 + 32'(4 * i));
        fork
            send(5'd9, 32'h999, 32'h4100);
            begin
                idle(3);
                wb_stall = 1'b0;
            end
        join
        idle(6);

        // Bypass priority.
        wb_stall  = 1'b1;
        send(5'd7, 32'hA, 32'h5000);
        send(5'd7, 32'hB, 32'h5004);
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd8;
        idle(2);
        wb_stall = 1'b0;
        idle(4);

        // Zero register is swallowed.
        rd_addr_a = 5'd0;
        send(5'd0, 32'hFFFF, 32'h6000);
        idle(3);

        // Back-to-back stream across pointer wrap.
        ws = writes_seen;
        for (int i = 0; i < 10; i++) send(5'(1 + i), 32'hC00 + 32'(i), 32'h7000 + 32'(4 * i));
        idle(3);
        chk("stream_write_count", 32'(writes_seen - ws), 32'd10);

        // Reset with two entries pending.
        wb_stall = 1'b1;
        send(5'd11, 32'hD1, 32'h8000);
        send(5'd12, 32'hD2, 32'h8004);
        reset = 1'b1;
        idle(2);
        reset    = 1'b0;
        wb_stall = 1'b0;
        ws = writes_seen;
        idle(4);
        chk("writes_after_reset", 32'(writes_seen - ws), 32'd0);

        // Randomized traffic obeying the valid/ready hold rule.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc || reset) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_addr  = 5'($urandom_range(0, 7));
                in_data  = $urandom;
                in_pc    = $urandom;
            end
            wb_stall  = ($urandom_range(0, 2) == 0);
            rd_addr_a = 5'($urandom_range(0, 7));
            rd_addr_b = 5'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 149) == 0);
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        wb_stall = 1'b0;
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
